// File: rtl/cr_kme_drbg_seed_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : cr_kme_drbg_seed_bank_if
// Purpose  : Register-write, grant/update and expiry signals of the seed bank.
// Revision : 1.0
// ============================================================================
interface cr_kme_drbg_seed_bank_if #(
  parameter int NUM_SEEDS = 2,
  parameter int ADDR_W    = 8
);
  logic                 wr_stb;
  logic [ADDR_W-1:0]    reg_addr;
  logic [31:0]          wr_data;
  logic [NUM_SEEDS-1:0] kdf_drbg_ctrl;
  logic                 wr_err;

  logic                 gen_req;
  logic                 gen_ack;
  logic                 gen_nack;
  logic [3:0]           gen_seed_idx;
  logic [255:0]         gen_key;
  logic [127:0]         gen_value;

  logic                 upd_vld;
  logic [255:0]         upd_key;
  logic [127:0]         upd_value;

  logic [NUM_SEEDS-1:0] expired_mask;
  logic                 set_drbg_expired_int;

  modport master (
    output wr_stb, reg_addr, wr_data, gen_req, upd_vld, upd_key, upd_value,
    input  kdf_drbg_ctrl, wr_err, gen_ack, gen_nack, gen_seed_idx, gen_key,
           gen_value, expired_mask, set_drbg_expired_int
  );

  modport slave (
    input  wr_stb, reg_addr, wr_data, gen_req, upd_vld, upd_key, upd_value,
    output kdf_drbg_ctrl, wr_err, gen_ack, gen_nack, gen_seed_idx, gen_key,
           gen_value, expired_mask, set_drbg_expired_int
  );
endinterface
`default_nettype wire

// File: rtl/cr_kme_drbg_seed_bank.sv
`default_nettype none
// ============================================================================
// Module   : cr_kme_drbg_seed_bank
// Purpose  : DRBG seed contexts with grant/update handshake and reseed expiry.
// Revision : 1.0
// ============================================================================
module cr_kme_drbg_seed_bank #(
  parameter int NUM_SEEDS  = 2,
  parameter int INTERVAL_W = 48,
  parameter int ADDR_W     = 8
) (
  input wire                     clk,
  input wire                     rst_n,
  cr_kme_drbg_seed_bank_if.slave bus
);

  localparam int                    c_BLK_W      = ADDR_W - 4;
  localparam logic [c_BLK_W-1:0]    c_BLK_ONE    = c_BLK_W'(1);
  localparam logic [c_BLK_W-1:0]    c_BLK_MAX    = c_BLK_W'(NUM_SEEDS);
  localparam logic [3:0]            c_OFF_KEY_HI = 4'd7;
  localparam logic [3:0]            c_OFF_VAL_HI = 4'd11;
  localparam logic [3:0]            c_OFF_INT_LO = 4'd12;
  localparam logic [3:0]            c_OFF_INT_HI = 4'd13;
  localparam logic [INTERVAL_W-1:0] c_CNT_ONE    = INTERVAL_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_WAIT_UPD = 2'd2
  } state_e;

  state_e                r_state;
  logic [255:0]          r_key      [NUM_SEEDS];
  logic [127:0]          r_value    [NUM_SEEDS];
  logic [INTERVAL_W-1:0] r_interval [NUM_SEEDS];
  logic [INTERVAL_W-1:0] r_use_cnt  [NUM_SEEDS];
  logic [NUM_SEEDS-1:0]  r_valid;
  logic [NUM_SEEDS-1:0]  r_expired;
  logic                  r_exp_int;
  logic                  r_wr_err;
  logic [3:0]            r_cur_idx;
  logic                  r_gen_ack;
  logic                  r_gen_nack;
  logic [3:0]            r_gen_seed_idx;
  logic [255:0]          r_gen_key;
  logic [127:0]          r_gen_value;

  logic [c_BLK_W-1:0]    w_blk;
  logic [3:0]            w_wr_off;
  logic [3:0]            w_wr_seed;
  logic                  w_ctrl_wr;
  logic                  w_seed_wr;
  logic                  w_wr_blocked;
  logic                  w_upd;
  logic [NUM_SEEDS-1:0]  w_cur_hit;
  logic [NUM_SEEDS-1:0]  w_expire;
  logic [INTERVAL_W-1:0] w_nxt_cnt [NUM_SEEDS];
  logic [3:0]            w_low_idx;
  logic [255:0]          w_low_key;
  logic [127:0]          w_low_value;

  always_comb begin
    w_wr_off     = bus.reg_addr[3:0];
    w_blk        = bus.reg_addr[ADDR_W-1:4];
    w_ctrl_wr    = bus.wr_stb && (bus.reg_addr == '0);
    w_seed_wr    = bus.wr_stb && (w_blk != '0) && (w_blk <= c_BLK_MAX) &&
                   (w_wr_off <= c_OFF_INT_HI);
    w_wr_seed    = 4'(w_blk - c_BLK_ONE);
    // The seed owned by an open transaction is frozen until its update returns
    w_wr_blocked = w_seed_wr && (r_state != ST_IDLE) && (w_wr_seed == r_cur_idx);
    w_upd        = (r_state == ST_WAIT_UPD) && bus.upd_vld;
  end

  always_comb begin
    w_cur_hit = '0;
    w_expire  = '0;
    for (int s = 0; s < NUM_SEEDS; s++) begin
      w_cur_hit[s] = (r_cur_idx == 4'(s));
      w_nxt_cnt[s] = (&r_use_cnt[s]) ? r_use_cnt[s] : r_use_cnt[s] + c_CNT_ONE;
      w_expire[s]  = w_upd && w_cur_hit[s] && r_valid[s] &&
                     (r_interval[s] != '0) && (w_nxt_cnt[s] >= r_interval[s]);
    end
  end

  always_comb begin
    w_low_idx   = '0;
    w_low_key   = r_key[0];
    w_low_value = r_value[0];
    for (int s = NUM_SEEDS - 1; s >= 0; s--) begin
      if (r_valid[s]) begin
        w_low_idx   = 4'(s);
        w_low_key   = r_key[s];
        w_low_value = r_value[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SEEDS; s++) begin
        r_key[s]      <= '0;
        r_value[s]    <= '0;
        r_interval[s] <= '0;
        r_use_cnt[s]  <= '0;
      end
      r_valid   <= '0;
      r_expired <= '0;
      r_exp_int <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_wr_err  <= w_wr_blocked;
      r_expired <= w_expire;
      r_exp_int <= |w_expire;
      for (int s = 0; s < NUM_SEEDS; s++) begin
        if (w_seed_wr && !w_wr_blocked && (w_wr_seed == 4'(s))) begin
          if (w_wr_off <= c_OFF_KEY_HI)
            r_key[s][{w_wr_off[2:0], 5'd0} +: 32] <= bus.wr_data;
          else if (w_wr_off <= c_OFF_VAL_HI)
            r_value[s][{w_wr_off[1:0], 5'd0} +: 32] <= bus.wr_data;
          else if (w_wr_off == c_OFF_INT_LO)
            r_interval[s][31:0] <= bus.wr_data;
          else
            r_interval[s][INTERVAL_W-1:32] <= bus.wr_data[INTERVAL_W-33:0];
        end
        if (w_upd && w_cur_hit[s]) begin
          r_key[s]   <= bus.upd_key;
          r_value[s] <= bus.upd_value;
        end
        if (w_ctrl_wr) begin
          r_valid[s] <= bus.wr_data[s];
          if (bus.wr_data[s] && !r_valid[s])
            r_use_cnt[s] <= '0;
        end
        // Expiry is placed last so it overrides a same-cycle CTRL write
        if (w_upd && w_cur_hit[s] && r_valid[s]) begin
          if (w_expire[s]) begin
            r_valid[s]   <= 1'b0;
            r_use_cnt[s] <= '0;
          end else begin
            r_use_cnt[s] <= w_nxt_cnt[s];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cur_idx      <= '0;
      r_gen_ack      <= 1'b0;
      r_gen_nack     <= 1'b0;
      r_gen_seed_idx <= '0;
      r_gen_key      <= '0;
      r_gen_value    <= '0;
    end else begin
      r_gen_ack  <= 1'b0;
      r_gen_nack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.gen_req) begin
            if (|r_valid) begin
              r_cur_idx      <= w_low_idx;
              r_gen_ack      <= 1'b1;
              r_gen_seed_idx <= w_low_idx;
              r_gen_key      <= w_low_key;
              r_gen_value    <= w_low_value;
              r_state        <= ST_GRANT;
            end else begin
              r_gen_nack <= 1'b1;
            end
          end
        end
        ST_GRANT:    r_state <= ST_WAIT_UPD;
        ST_WAIT_UPD: if (bus.upd_vld) r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.kdf_drbg_ctrl        = r_valid;
  assign bus.wr_err               = r_wr_err;
  assign bus.gen_ack              = r_gen_ack;
  assign bus.gen_nack             = r_gen_nack;
  assign bus.gen_seed_idx         = r_gen_seed_idx;
  assign bus.gen_key              = r_gen_key;
  assign bus.gen_value            = r_gen_value;
  assign bus.expired_mask         = r_expired;
  assign bus.set_drbg_expired_int = r_exp_int;

endmodule
`default_nettype wire

// File: tb/tb_cr_kme_drbg_seed_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr_kme_drbg_seed_bank
// Purpose  : Self-checking bench for the DRBG seed bank.
// Revision : 1.0
// ============================================================================
module tb_cr_kme_drbg_seed_bank;
  localparam int NS = 2;
  localparam int IW = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cr_kme_drbg_seed_bank_if #(.NUM_SEEDS(NS), .ADDR_W(8)) bus ();

  cr_kme_drbg_seed_bank #(.NUM_SEEDS(NS), .INTERVAL_W(IW), .ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the seed store
  logic [255:0]   m_key [NS];
  logic [127:0]   m_val [NS];
  logic [IW-1:0]  m_int [NS];
  logic [IW-1:0]  m_cnt [NS];
  logic [NS-1:0]  m_valid;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        req;
    logic [1:0]  exp_ctrl;
    logic        exp_nack;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.wr_stb = 1'b1; bus.reg_addr = a; bus.wr_data = d;
    tick();
    bus.wr_stb = 1'b0; bus.reg_addr = '0; bus.wr_data = '0;
  endtask

  task automatic load_seed(input int s, input logic [255:0] k, input logic [127:0] v,
                           input logic [63:0] iv);
    for (int i = 0; i < 8; i++) wr(8'(16 * (s + 1) + i), k[32*i +: 32]);
    for (int i = 0; i < 4; i++) wr(8'(16 * (s + 1) + 8 + i), v[32*i +: 32]);
    wr(8'(16 * (s + 1) + 12), iv[31:0]);
    wr(8'(16 * (s + 1) + 13), iv[63:32]);
  endtask

  task automatic req();
    bus.gen_req = 1'b1;
    tick();
    bus.gen_req = 1'b0;
  endtask

  task automatic upd(input logic [255:0] k, input logic [127:0] v);
    bus.upd_vld = 1'b1; bus.upd_key = k; bus.upd_value = v;
    tick();
    bus.upd_vld = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ack"},  bus.gen_ack, 0);
    check({tag, "_nack"}, bus.gen_nack, 0);
    check({tag, "_err"},  bus.wr_err, 0);
    check({tag, "_mask"}, bus.expired_mask, 0);
    check({tag, "_int"},  bus.set_drbg_expired_int, 0);
    check({tag, "_ctrl"}, bus.kdf_drbg_ctrl, 0);
    check({tag, "_idx"},  bus.gen_seed_idx, 0);
    check({tag, "_key"},  bus.gen_key, 0);
    check({tag, "_val"},  bus.gen_value, 0);
  endtask

  task automatic m_write(input logic [7:0] a, input logic [31:0] d, input logic busy,
                         input int cur, output logic err);
    int blk, off, s;
    blk = int'(a) / 16;
    off = int'(a) % 16;
    s   = blk - 1;
    err = 1'b0;
    if (a == 8'h00) begin
      for (int i = 0; i < NS; i++) if (d[i] && !m_valid[i]) m_cnt[i] = '0;
      m_valid = d[NS-1:0];
    end else if (blk != 0 && s < NS && off <= 13) begin
      if (busy && s == cur) err = 1'b1;
      else if (off < 8)     m_key[s][off*32 +: 32] = d;
      else if (off < 12)    m_val[s][(off-8)*32 +: 32] = d;
      else if (off == 12)   m_int[s][31:0] = d;
      else                  m_int[s][IW-1:32] = d[IW-33:0];
    end
  endtask

  task automatic m_update(input int cur, input logic [255:0] k, input logic [127:0] v,
                          output logic [NS-1:0] mask);
    logic [IW-1:0] nxt;
    mask = '0;
    m_key[cur] = k;
    m_val[cur] = v;
    if (m_valid[cur]) begin
      nxt = (m_cnt[cur] == {IW{1'b1}}) ? m_cnt[cur] : m_cnt[cur] + 1;
      if (m_int[cur] != 0 && nxt >= m_int[cur]) begin
        m_valid[cur] = 1'b0;
        m_cnt[cur]   = '0;
        mask[cur]    = 1'b1;
      end else begin
        m_cnt[cur] = nxt;
      end
    end
  endtask

  task automatic rand_write(output logic [7:0] a, output logic [31:0] d);
    int s, off;
    if ($urandom_range(0, 3) == 0) begin
      a = 8'h00;
      d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3));
    end else begin
      s   = $urandom_range(0, NS);
      off = $urandom_range(0, 15);
      a   = 8'(16 * (s + 1) + off);
      if (off == 12)      d = 32'($urandom_range(0, 4));
      else if (off == 13) d = ($urandom_range(0, 5) == 0) ? $urandom : 32'h0;
      else                d = $urandom;
    end
  endtask

  task automatic rand_kv(output logic [255:0] k, output logic [127:0] v);
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    for (int i = 0; i < 4; i++) v[32*i +: 32] = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [255:0]  k0, k1, kr, ka5;
    logic [127:0]  v0, v1, vr, va5;
    logic [7:0]    a;
    logic [31:0]   d;
    logic          err;
    logic [NS-1:0] mask;
    int            cur;

    bus.wr_stb = 1'b0; bus.reg_addr = '0; bus.wr_data = '0; bus.gen_req = 1'b0;
    bus.upd_vld = 1'b0; bus.upd_key = '0; bus.upd_value = '0;

    rst_n = 1'b0;
    tick();
    check_reset_state("reset");
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Single-cycle register/nack vectors
    vecs[0] = '{1'b1, 8'h00, 32'h0000_0000, 1'b0, 2'b00, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 32'h0000_0000, 1'b1, 2'b00, 1'b1};
    vecs[2] = '{1'b1, 8'h00, 32'h0000_0002, 1'b0, 2'b10, 1'b0};
    vecs[3] = '{1'b1, 8'h40, 32'h0000_0003, 1'b0, 2'b10, 1'b0};
    vecs[4] = '{1'b1, 8'h01, 32'h0000_0003, 1'b0, 2'b10, 1'b0};
    vecs[5] = '{1'b1, 8'h00, 32'hFFFF_FFFC, 1'b0, 2'b00, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 32'h0000_0001, 1'b1, 2'b01, 1'b1};
    vecs[7] = '{1'b1, 8'h00, 32'h0000_0000, 1'b0, 2'b00, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 32'h0000_0000, 1'b0, 2'b00, 1'b0};
    for (int i = 0; i < 9; i++) begin
      bus.wr_stb = vecs[i].wr; bus.reg_addr = vecs[i].addr;
      bus.wr_data = vecs[i].data; bus.gen_req = vecs[i].req;
      tick();
      bus.wr_stb = 1'b0; bus.reg_addr = '0; bus.wr_data = '0; bus.gen_req = 1'b0;
      check($sformatf("vec%0d_ctrl", i), bus.kdf_drbg_ctrl, vecs[i].exp_ctrl);
      check($sformatf("vec%0d_nack", i), bus.gen_nack, vecs[i].exp_nack);
    end

    // Basic grant and expiry after three uses
    for (int i = 0; i < 8; i++) k0[32*i +: 32] = 32'(i);
    v0  = {32'h13, 32'h12, 32'h11, 32'h10};
    ka5 = {8{32'hA5A5_A5A5}};
    va5 = {4{32'h5A5A_5A5A}};
    load_seed(0, k0, v0, 64'd3);
    wr(8'h00, 32'h1);
    check("ctrl_after_load", bus.kdf_drbg_ctrl, 2'b01);
    req();
    check("grant_ack", bus.gen_ack, 1);
    check("grant_idx", bus.gen_seed_idx, 0);
    check("grant_key_w0", bus.gen_key[31:0], 0);
    check("grant_key", bus.gen_key, k0);
    check("grant_value", bus.gen_value, v0);
    tick();
    check("ack_one_cycle", bus.gen_ack, 0);
    upd(ka5, va5);
    check("use1_no_expiry", bus.expired_mask, 0);
    req();
    check("regrant_key", bus.gen_key, ka5);
    check("regrant_value", bus.gen_value, va5);
    tick();
    upd(ka5, va5);
    check("use2_no_expiry", bus.expired_mask, 0);
    req();
    tick();
    upd(ka5, va5);
    check("expiry_mask", bus.expired_mask, 2'b01);
    check("expiry_int", bus.set_drbg_expired_int, 1);
    check("expiry_ctrl", bus.kdf_drbg_ctrl, 2'b00);
    tick();
    check("expiry_pulse_end", bus.expired_mask, 0);
    check("expiry_int_end", bus.set_drbg_expired_int, 0);
    req();
    check("nack_no_valid", bus.gen_nack, 1);
    check("no_ack_on_nack", bus.gen_ack, 0);
    tick();
    check("nack_pulse_end", bus.gen_nack, 0);

    // Failover from an expiring seed 0 to seed 1
    wr(8'h1C, 32'd1);
    wr(8'h1D, 32'd0);
    for (int i = 0; i < 8; i++) k1[32*i +: 32] = 32'h100 + 32'(i);
    v1 = {32'h203, 32'h202, 32'h201, 32'h200};
    load_seed(1, k1, v1, 64'd0);
    wr(8'h00, 32'h3);
    check("failover_ctrl", bus.kdf_drbg_ctrl, 2'b11);
    req();
    check("failover_first_idx", bus.gen_seed_idx, 0);
    tick();
    upd({8{32'h3333_3333}}, {4{32'h3333_3333}});
    check("failover_expiry", bus.expired_mask, 2'b01);
    check("failover_ctrl_after", bus.kdf_drbg_ctrl, 2'b10);
    req();
    check("failover_second_idx", bus.gen_seed_idx, 1);
    check("failover_second_key", bus.gen_key, k1);
    tick();

    // Writes against the seed held by an open transaction
    wr(8'h2C, 32'd1);
    check("inuse_interval_wr_err", bus.wr_err, 1);
    wr(8'h20, 32'h0000_DEAD);
    check("inuse_key_wr_err", bus.wr_err, 1);
    wr(8'h10, 32'h0000_BEEF);
    check("other_seed_no_wr_err", bus.wr_err, 0);
    upd({8{32'h4444_4444}}, {4{32'h4444_4444}});
    check("blocked_interval_kept", bus.expired_mask, 0);
    check("inuse_ctrl", bus.kdf_drbg_ctrl, 2'b10);
    wr(8'h00, 32'h3);
    req();
    check("other_seed_idx", bus.gen_seed_idx, 0);
    check("other_seed_key", bus.gen_key, {{7{32'h3333_3333}}, 32'h0000_BEEF});
    tick();

    // CTRL write colliding with an expiring update
    bus.wr_stb = 1'b1; bus.reg_addr = 8'h00; bus.wr_data = 32'h1;
    upd({8{32'h5555_5555}}, {4{32'h5555_5555}});
    bus.wr_stb = 1'b0; bus.wr_data = '0;
    check("collision_mask", bus.expired_mask, 2'b01);
    check("collision_ctrl", bus.kdf_drbg_ctrl, 2'b00);

    // Interval 0 never expires
    wr(8'h00, 32'h2);
    for (int i = 0; i < 10; i++) begin
      req();
      check($sformatf("nozero_idx%0d", i), bus.gen_seed_idx, 1);
      tick();
      upd(k1, v1);
      check($sformatf("nozero_mask%0d", i), bus.expired_mask, 0);
    end
    check("nozero_ctrl", bus.kdf_drbg_ctrl, 2'b10);

    // Reset in the middle of a transaction
    req();
    check("pre_reset_ack", bus.gen_ack, 1);
    rst_n = 1'b0;
    #2;
    check_reset_state("midreset");
    @(negedge clk) rst_n = 1'b1;
    tick();
    upd(ka5, va5);
    check("post_reset_upd_mask", bus.expired_mask, 0);
    check("post_reset_upd_ack", bus.gen_ack, 0);
    req();
    check("post_reset_nack", bus.gen_nack, 1);
    tick();
    wr(8'h00, 32'h1);
    req();
    check("post_reset_ack", bus.gen_ack, 1);
    check("key_cleared_by_reset", bus.gen_key, 0);
    tick();
    upd('0, '0);

    // Randomized traffic against the reference model
    rst_n = 1'b0;
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    m_valid = '0;
    for (int s = 0; s < NS; s++) begin
      m_key[s] = '0; m_val[s] = '0; m_int[s] = '0; m_cnt[s] = '0;
    end
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        rand_write(a, d);
        m_write(a, d, 1'b0, 0, err);
        wr(a, d);
        check("rnd_idle_wr_err", bus.wr_err, err);
        check("rnd_idle_ctrl", bus.kdf_drbg_ctrl, m_valid);
      end else begin
        cur = -1;
        for (int s = NS - 1; s >= 0; s--) if (m_valid[s]) cur = s;
        req();
        if (cur < 0) begin
          check("rnd_nack", bus.gen_nack, 1);
          check("rnd_nack_ack", bus.gen_ack, 0);
        end else begin
          check("rnd_ack", bus.gen_ack, 1);
          check("rnd_idx", bus.gen_seed_idx, 4'(cur));
          check("rnd_key", bus.gen_key, m_key[cur]);
          check("rnd_value", bus.gen_value, m_val[cur]);
          tick();
          if ($urandom_range(0, 1) == 1) begin
            rand_write(a, d);
            m_write(a, d, 1'b1, cur, err);
            wr(a, d);
            check("rnd_busy_wr_err", bus.wr_err, err);
            check("rnd_busy_ctrl", bus.kdf_drbg_ctrl, m_valid);
          end
          rand_kv(kr, vr);
          m_update(cur, kr, vr, mask);
          upd(kr, vr);
          check("rnd_exp_mask", bus.expired_mask, mask);
          check("rnd_exp_int", bus.set_drbg_expired_int, |mask);
          check("rnd_upd_ctrl", bus.kdf_drbg_ctrl, m_valid);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cr_kme_drbg_seed_bank.md
# cr_kme_drbg_seed_bank

Parametrised DRBG seed store for the KME KDF path. It holds NUM_SEEDS independent seed contexts, each with a 256-bit key, a 128-bit value and a reseed interval, all loaded by 32-bit register writes. It grants seeds to the DRBG engine over a request/ack handshake, takes the updated internal state back from the engine, counts uses per seed and invalidates a seed when its reseed interval expires. It sits between the KME register file and the KDF DRBG engine.

## Interface
- NUM_SEEDS, 2: number of seed contexts, 1..15.
- INTERVAL_W, 48: reseed interval and use-counter width, 33..64.
- ADDR_W, 8: register word-address width.
- Clock is clk. Reset is rst_n: asynchronous, active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_stb  in  1  register write strobe.
- reg_addr  in  ADDR_W  word address.
- wr_data  in  32  write data.
- kdf_drbg_ctrl  out  NUM_SEEDS  per-seed valid readback.
- wr_err  out  1  1-cycle pulse: write dropped because the target seed is in use.
- gen_req  in  1  engine requests a seed; level, sampled only in IDLE.
- gen_ack  out  1  1-cycle pulse: the gen_* data is valid.
- gen_nack  out  1  1-cycle pulse: request refused because no seed is valid.
- gen_seed_idx  out  4  index of the granted seed.
- gen_key  out  256  key of the granted seed.
- gen_value  out  128  value of the granted seed.
- upd_vld  in  1  engine returns the updated state for the granted seed.
- upd_key  in  256  updated key.
- upd_value  in  128  updated value.
- expired_mask  out  NUM_SEEDS  1-cycle pulse per seed that expired.
- set_drbg_expired_int  out  1  OR of expired_mask.

## Operation
- Address map:
  - Word 0 is CTRL; wr_data[NUM_SEEDS-1:0] is the valid vector.
  - Seed s occupies base 16*(s+1).
  - Offsets 0..7: key words [31:0]..[255:224].
  - Offsets 8..11: value words [31:0]..[127:96].
  - Offset 12: interval[31:0]. Offset 13: interval[INTERVAL_W-1:32].
  - Other offsets, and seeds at index ≥ NUM_SEEDS, are ignored.
- CTRL write:
  - Sets valid[s] = wr_data[s].
  - A 0→1 transition clears use_cnt[s] to 0.
- Invalidation has priority over writes, as in the existing DRBG control.
- Seed state in use:
  - While FSM ≠ IDLE, a key, value or interval write to seed cur_idx is dropped and wr_err pulses the next cycle.
  - CTRL writes are always accepted. Clearing valid[cur_idx] mid-transaction is allowed; the pending update still stores key and value but does not count or expire the seed.
- FSM states:
  - IDLE:
    - If gen_req and any seed is valid: latch cur_idx = lowest valid index, go to GRANT.
    - If gen_req and no seed is valid: pulse gen_nack, stay in IDLE.
  - GRANT: gen_ack = 1; gen_seed_idx, gen_key and gen_value are registered from cur_idx. Go to WAIT_UPD.
  - WAIT_UPD: wait for upd_vld. On upd_vld:
    - Write upd_key and upd_value into seed cur_idx.
    - If valid[cur_idx]: nxt = use_cnt+1, saturating at all-ones.
    - If interval ≠ 0 and nxt ≥ interval: clear valid[cur_idx], zero use_cnt, pulse expired_mask[cur_idx] the next cycle.
    - Otherwise use_cnt = nxt.
    - Return to IDLE.
- Interval 0 means the seed never expires.
- upd_vld outside WAIT_UPD is ignored.
- A CTRL write setting valid[cur_idx] in the same cycle as an expiring upd_vld: expiry wins, valid ends at 0.

## Timing
- Reset values (all async):
  - Valid vector, use counters, key/value/interval storage, and gen_key/gen_value/gen_seed_idx all 0.
  - gen_ack, gen_nack, wr_err, expired_mask and set_drbg_expired_int all 0.
  - FSM in IDLE.
- Reset mid-transaction returns the FSM to IDLE and clears all seeds. No ack or expiry pulse is emitted after reset.
- Request path:
  - gen_req sampled at edge N in IDLE → gen_ack high in cycle N+1. gen_nack has the same latency.
  - Minimum turnaround: upd_vld at edge M → a new request can be sampled at M+1.
- Register writes take effect at the next edge; readback is visible one cycle later.
- wr_err and expired_mask are registered: they pulse one cycle after the causing edge.
- kdf_drbg_ctrl is the register output directly.

## Test plan
- Basic grant:
  - Stimulus: NUM_SEEDS=2. Load seed0 key words 0x0..0x7 and value 0x10..0x13; interval=3; CTRL=0x1. gen_req.
  - Required: gen_ack one cycle after the sampled request, gen_seed_idx=0, gen_key[31:0]=0x0.
  - Stimulus: return upd_key=all-0xA5.
  - Required: the next grant shows 0xA5A5A5A5.
- Expiry:
  - Stimulus: 3 request/update cycles on interval=3.
  - Required: after the 3rd upd_vld, expired_mask=0b01 and set_drbg_expired_int pulse one cycle; kdf_drbg_ctrl=0b00; the next gen_req gives gen_nack.
- Failover:
  - Stimulus: seeds 0 and 1 valid, seed0 interval=1.
  - Required: the first grant goes to idx 0, which expires. The second grant goes to idx 1.
- In-use protection:
  - Stimulus: in WAIT_UPD for seed0, write seed0 key word 0.
  - Required: wr_err pulses and the key is unchanged.
  - Stimulus: the same write to seed1.
  - Required: accepted, no wr_err.
- Collision and saturation:
  - Stimulus: CTRL=0x1 in the same cycle as an expiring upd_vld.
  - Required: valid=0, expiry pulse.
  - Stimulus: interval=0 with 10 uses.
  - Required: never expires.
- Reset:
  - Stimulus: assert rst_n in GRANT or WAIT_UPD.
  - Required: all outputs 0, FSM in IDLE; a later upd_vld is ignored.
